// File: rtl/sine_cfg_ctrl_if.sv
// UART byte-stream bundle between the receiver/transmitter and sine_cfg_ctrl.
// The controller sits on the slave side: it consumes rx bytes and offers tx bytes.
interface sine_cfg_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/sine_cfg_ctrl.sv
// Parses 3-byte UART command frames into sine generator settings and replies with
// acknowledge/readback bytes; board switches select phase-increment presets.
module sine_cfg_ctrl #(
    parameter logic [15:0] PRESET0 = 16'h0100,
    parameter logic [15:0] PRESET1 = 16'h0200,
    parameter logic [15:0] PRESET2 = 16'h0400,
    parameter logic [15:0] PRESET3 = 16'h0800,
    parameter int          TIMEOUT = 100000
) (
    input  logic                  clk1,
    input  logic                  rst,
    sine_cfg_ctrl_if.slave        uart,
    input  logic                  sw_0,
    input  logic                  sw_1,
    output logic [15:0]           phase_inc,
    output logic [7:0]            amplitude,
    output logic                  wave_en,
    output logic                  cfg_update,
    output logic                  busy
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [7:0] CMD_F = 8'h46;
    localparam logic [7:0] CMD_A = 8'h41;
    localparam logic [7:0] CMD_E = 8'h45;
    localparam logic [7:0] CMD_Q = 8'h51;
    localparam logic [7:0] ACK_K = 8'h4B;
    localparam logic [7:0] NAK_N = 8'h4E;

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        EXEC,
        REPLY
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [15:0]       phase_q, phase_d;
    logic [7:0]        amp_q, amp_d;
    logic              wen_q, wen_d;
    logic              cfgu_q, cfgu_d;
    logic              txv_q, txv_d;
    logic [7:0]        txd_q, txd_d;
    logic [23:0]       rest_q, rest_d;
    logic [1:0]        rem_q, rem_d;
    logic [1:0]        sw_s1_q, sw_s1_d;
    logic [1:0]        sw_s2_q, sw_s2_d;
    logic [1:0]        sw_prev_q, sw_prev_d;
    logic              sw_load;
    logic              cfg_write;

    function automatic logic is_known_cmd(input logic [7:0] c);
        return (c == CMD_F) || (c == CMD_A) || (c == CMD_E) || (c == CMD_Q);
    endfunction

    function automatic logic [15:0] preset_sel(input logic [1:0] sw);
        case (sw)
            2'b00:   return PRESET0;
            2'b01:   return PRESET1;
            2'b10:   return PRESET2;
            default: return PRESET3;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        phase_d   = phase_q;
        amp_d     = amp_q;
        wen_d     = wen_q;
        txv_d     = txv_q;
        txd_d     = txd_q;
        rest_d    = rest_q;
        rem_d     = rem_q;
        cfg_write = 1'b0;
        sw_s1_d   = {sw_1, sw_0};
        sw_s2_d   = sw_s1_q;
        sw_prev_d = sw_s2_q;

        // Reset clears the sync chain to 00, so a non-00 switch setting reloads here too.
        sw_load = (sw_s2_q != sw_prev_q);
        if (sw_load) begin
            phase_d = preset_sel(sw_s2_q);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (uart.rx_valid) begin
                    if (is_known_cmd(uart.rx_data)) begin
                        cmd_d   = uart.rx_data;
                        state_d = GET_HI;
                    end else begin
                        txd_d   = NAK_N;
                        rem_d   = 2'd0;
                        state_d = REPLY;
                    end
                end
            end
            GET_HI: begin
                if (uart.rx_valid) begin
                    hi_d    = uart.rx_data;
                    cnt_d   = '0;
                    state_d = GET_LO;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GET_LO: begin
                if (uart.rx_valid) begin
                    lo_d    = uart.rx_data;
                    cnt_d   = '0;
                    state_d = EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXEC: begin
                // UART write comes after the preset load so it wins on a collision.
                case (cmd_q)
                    CMD_F: begin
                        phase_d   = {hi_q, lo_q};
                        cfg_write = 1'b1;
                    end
                    CMD_A: begin
                        amp_d     = lo_q;
                        cfg_write = 1'b1;
                    end
                    CMD_E: begin
                        wen_d     = lo_q[0];
                        cfg_write = 1'b1;
                    end
                    default: ;
                endcase
                txv_d = 1'b1;
                txd_d = ACK_K;
                if (cmd_q == CMD_Q) begin
                    rest_d = {phase_q, amp_q};
                    rem_d  = 2'd3;
                end else begin
                    rem_d  = 2'd0;
                end
                state_d = REPLY;
            end
            REPLY: begin
                // Entered straight from IDLE on an unknown command: raise valid one edge later.
                if (!txv_q) begin
                    txv_d = 1'b1;
                end else if (uart.tx_ready) begin
                    if (rem_q == 2'd0) begin
                        txv_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        txd_d  = rest_q[23:16];
                        rest_d = {rest_q[15:0], 8'h00};
                        rem_d  = rem_q - 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cfgu_d = sw_load | cfg_write;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            phase_q   <= PRESET0;
            amp_q     <= 8'hFF;
            wen_q     <= 1'b0;
            cfgu_q    <= 1'b0;
            txv_q     <= 1'b0;
            txd_q     <= 8'h00;
            rem_q     <= 2'd0;
            sw_s1_q   <= 2'b00;
            sw_s2_q   <= 2'b00;
            sw_prev_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            amp_q     <= amp_d;
            wen_q     <= wen_d;
            cfgu_q    <= cfgu_d;
            txv_q     <= txv_d;
            txd_q     <= txd_d;
            rem_q     <= rem_d;
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            sw_prev_q <= sw_prev_d;
        end
    end

    always_ff @(posedge clk1) begin
        cmd_q  <= cmd_d;
        hi_q   <= hi_d;
        lo_q   <= lo_d;
        rest_q <= rest_d;
    end

    assign phase_inc     = phase_q;
    assign amplitude     = amp_q;
    assign wave_en       = wen_q;
    assign cfg_update    = cfgu_q;
    assign busy          = (state_q != IDLE);
    assign uart.tx_valid = txv_q;
    assign uart.tx_data  = txd_q;

endmodule

// File: doc/sine_cfg_ctrl.md
# sine_cfg_ctrl

UART command controller that configures and sequences the PWM sine generator. It takes received bytes from the UART receiver, parses fixed 3-byte command frames, and updates the generator's phase increment, amplitude and enable. It returns acknowledge/readback bytes to the UART transmitter. The two board switches select phase-increment presets, and UART writes override a preset until the next switch change.

## Interface
Parameters:
- `PRESET0`, default 16'h0100: phase increment for switches {sw_1,sw_0}=00; also the reset value.
- `PRESET1`, default 16'h0200: phase increment for {sw_1,sw_0}=01.
- `PRESET2`, default 16'h0400: phase increment for {sw_1,sw_0}=10.
- `PRESET3`, default 16'h0800: phase increment for {sw_1,sw_0}=11.
- `TIMEOUT`, default 100000: inter-byte timeout in clk1 cycles. The counter width is $clog2(TIMEOUT+1).

Ports:
- `clk1` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid while it is high.
- `tx_data` out 8: reply byte.
- `tx_valid` out 1: reply byte available. Held until accepted.
- `tx_ready` in 1: transmitter accepts; a transfer occurs when `tx_valid` and `tx_ready` are both high.
- `sw_0`, `sw_1` in 1: asynchronous switch pins.
- `phase_inc` out 16: sine phase accumulator step.
- `amplitude` out 8: sine amplitude scale.
- `wave_en` out 1: PWM output enable.
- `cfg_update` out 1: one-cycle pulse whenever any configuration output is written.
- `busy` out 1: high in any state other than IDLE.

## Operation
Frame format: CMD, HI, LO, one byte per `rx_valid` strobe. The HI and LO data bytes are ignored where a command does not use them.

Commands:
- 0x46 'F': `phase_inc` <= {HI,LO}. Reply 'K' (0x4B).
- 0x41 'A': `amplitude` <= LO. Reply 'K'.
- 0x45 'E': `wave_en` <= LO[0]. Reply 'K'.
- 0x51 'Q': no configuration write and no `cfg_update`. Reply 4 bytes: 'K', `phase_inc`[15:8], `phase_inc`[7:0], `amplitude`.
- Any other CMD: reply 'N' (0x4E) immediately, without consuming HI/LO. Return to IDLE after the reply.

States:
- IDLE: on `rx_valid`, a valid CMD goes to GET_HI; an unknown CMD goes to REPLY.
- GET_HI: on `rx_valid`, go to GET_LO. On timeout, go to IDLE.
- GET_LO: on `rx_valid`, go to EXEC. On timeout, go to IDLE.
- EXEC: exactly one cycle. Write the configuration, load the reply buffer, go to REPLY.
- REPLY: drive the bytes in order. Advance on each handshake. After the last byte is accepted, go to IDLE.

Timeout rules:
- The counter clears on every accepted byte and counts only in GET_HI and GET_LO.
- When the counter reaches TIMEOUT, the partial frame is discarded silently: no reply and no write.

Overrun:
- An `rx_valid` strobe in EXEC or REPLY drops the byte.

Switch presets:
- `sw_0` and `sw_1` each pass through a two-flop synchronizer; the synchronizer flops reset to 0.
- A change in the synchronized {sw_1,sw_0} loads `phase_inc` <= PRESETn and pulses `cfg_update`.
- This load includes the post-reset settle. If the switches are not 00 at reset, the preset loads within 3 cycles.
- If a switch load and an EXEC 'F' write land in the same cycle, the UART value wins. `cfg_update` pulses once.
- An 'A' or 'E' write in the same cycle as a switch load applies both.

Reset (`rst` high at an edge):
- The state goes to IDLE, the counter clears and any partial frame or reply is discarded.
- `tx_valid` drops at the next edge, even in the middle of a reply.

## Timing
Output values after reset:
- `phase_inc`=PRESET0, `amplitude`=8'hFF, `wave_en`=0.
- `tx_valid`=0, `tx_data`=0.
- `cfg_update`=0, `busy`=0.

Command latency, with the LO byte sampled at edge k:
- EXEC occupies the cycle after edge k.
- The configuration outputs change at edge k+1. `cfg_update` is high for that one following cycle.
- `tx_valid` rises at edge k+1 with the first reply byte.

Unknown-command latency, with CMD sampled at edge k:
- `tx_valid` rises at edge k+1 with 'N'.

Reply handshake:
- `tx_data` is stable while `tx_valid` is high and `tx_ready` is low.
- After a handshake at edge m, the next reply byte appears at edge m; `tx_valid` stays high.
- After the final byte, `tx_valid` falls at edge m.

Frame throughput:
- A new CMD is accepted in the cycle after the return to IDLE.
- Back-to-back `rx_valid` strobes in consecutive cycles are accepted while in IDLE, GET_HI and GET_LO.

Timeout:
- The timeout fires on the TIMEOUT-th idle cycle after the last accepted byte, and the state is IDLE on the next cycle.

## Test plan
- Reset → `phase_inc`=0x0100, `amplitude`=0xFF, `wave_en`=0, `tx_valid`=0, `busy`=0.
- Bytes 46 12 34 with `tx_ready`=1 → `phase_inc`=0x1234 two edges after the LO byte, one `cfg_update` pulse, one byte 0x4B sent.
- Bytes 41 00 80, then 51 00 00, with `tx_ready` held low for 5 cycles per byte → `amplitude`=0x80. The readback is 4B 12 34 80, with `tx_data` stable while `tx_ready`=0.
- Byte 5A → 'N' (0x4E) sent. The following bytes 45 00 01 execute normally: `wave_en`=1, 'K' sent.
- Bytes 46 AA, then silence for TIMEOUT cycles → no reply, `phase_inc` unchanged. A next byte 45 is treated as a CMD.
- Switches 00→10 → `phase_inc`=0x0400 within 3 cycles. With 'F' EXEC coincident with a switch change → the UART value wins and `cfg_update` pulses once. `rst` during REPLY → `tx_valid`=0 at the next edge.
